fir_tap_sequencer: RTL and testbench

- Controller for a single shared multiply-accumulate datapath running an N_TAPS FIR filter.
- Per accepted input sample it:
  - writes the sample into a circular delay-line RAM;
  - walks all N_TAPS taps, one per clock_in cycle, driving delay-line read and coefficient addresses plus MAC control;
  - waits out the MAC pipeline latency, then pulses result_valid.
- Sits between the sample source (strobed from the divided clock domain logic) and the MAC/RAM datapath.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_tap_sequencer_mod_counter.sv | 25 ++
 rtl/fir_tap_sequencer.sv | 101 ++++++++++
 tb/tb_fir_tap_sequencer.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR tap sequencer: FSM states, default
// sizing, and modulo arithmetic for circular delay-line pointers.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } fir_state_e;

  localparam int unsigned N_TAPS_DEF  = 16;
  localparam int unsigned MAC_LAT_DEF = 2;

  // Returns (ptr - step) mod modulus; requires ptr < modulus and step < modulus.
  function automatic int unsigned wrap_dec(input int unsigned ptr,
                                           input int unsigned step,
                                           input int unsigned modulus);
    return (ptr >= step) ? (ptr - step) : (ptr + modulus - step);
  endfunction

endpackage

// File: rtl/fir_tap_sequencer_mod_counter.sv
// Modulo-MOD up counter with synchronous clear; wrap flags the terminal
// count in a cycle where the counter advances.
module mod_counter #(
  parameter  int unsigned MOD = 16,
  localparam int unsigned W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clock_in,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(MOD - 1));

  always_ff @(posedge clock_in) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Sequencer for a shared MAC running an N_TAPS FIR: accepts a sample, walks
// every tap once per cycle, waits out MAC latency, then flags the result.
module fir_tap_sequencer
  import fir_pkg::*;
#(
  parameter  int unsigned N_TAPS  = N_TAPS_DEF,
  parameter  int unsigned MAC_LAT = MAC_LAT_DEF,
  localparam int unsigned AW      = $clog2(N_TAPS)
) (
  input  logic          clock_in,
  input  logic          rst,
  input  logic          sample_valid,
  output logic          sample_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clear,
  output logic          result_valid,
  output logic          overrun,
  input  logic          overrun_clr
);

  fir_state_e    state, state_n;
  logic          accept, drop;
  logic          k_wrap, wr_wrap;
  logic [AW-1:0] k, base, rd_n;
  logic [2:0]    drain_cnt;

  assign sample_ready = (state == IDLE) && !rst;
  assign accept       = sample_ready && sample_valid;
  assign drop         = sample_valid && !sample_ready;
  assign wr_en        = accept;
  assign coef_addr    = k;

  mod_counter #(.MOD(N_TAPS)) u_wr_ctr (
    .clock_in (clock_in),
    .rst      (rst),
    .en       (accept),
    .clr      (1'b0),
    .count    (wr_ptr),
    .wrap     (wr_wrap)
  );

  mod_counter #(.MOD(N_TAPS)) u_tap_ctr (
    .clock_in (clock_in),
    .rst      (rst),
    .en       (state == RUN),
    .clr      (accept),
    .count    (k),
    .wrap     (k_wrap)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept) state_n = RUN;
      RUN:     if (k_wrap) state_n = (MAC_LAT == 0) ? IDLE : DRAIN;
      DRAIN:   if (32'(drain_cnt) + 32'd1 >= MAC_LAT) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // rd_ptr is registered, so it is computed from the tap index it will show next cycle.
  always_comb begin
    rd_n = rd_ptr;
    if (accept) begin
      rd_n = wr_ptr;
    end else if ((state == RUN) && !k_wrap) begin
      rd_n = AW'(wrap_dec(32'(base), 32'(k) + 32'd1, N_TAPS));
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      state        <= IDLE;
      base         <= '0;
      drain_cnt    <= '0;
      rd_ptr       <= '0;
      mac_en       <= 1'b0;
      mac_clear    <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_n;
      if (accept) base <= wr_ptr;
      drain_cnt    <= ((state == DRAIN) && (state_n == DRAIN)) ? drain_cnt + 3'd1 : '0;
      rd_ptr       <= rd_n;
      mac_en       <= (state_n == RUN);
      mac_clear    <= accept;
      result_valid <= (state != IDLE) && (state_n == IDLE);
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: two instances (16 taps/lat 2, 5 taps/lat 0)
// checked every cycle against a timeline model keyed on cycles since acceptance.
module tb_fir_tap_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sv [2];
  logic clr[2];
  logic rst[2];

  logic       rdy0, wen0, me0, mc0, rv0, ov0;
  logic [3:0] wp0, rp0, ca0;
  logic       rdy1, wen1, me1, mc1, rv1, ov1;
  logic [2:0] wp1, rp1, ca1;

  fir_tap_sequencer #(.N_TAPS(16), .MAC_LAT(2)) dut0 (
    .clock_in(clk), .rst(rst[0]), .sample_valid(sv[0]), .sample_ready(rdy0),
    .wr_en(wen0), .wr_ptr(wp0), .rd_ptr(rp0), .coef_addr(ca0), .mac_en(me0),
    .mac_clear(mc0), .result_valid(rv0), .overrun(ov0), .overrun_clr(clr[0])
  );

  fir_tap_sequencer #(.N_TAPS(5), .MAC_LAT(0)) dut1 (
    .clock_in(clk), .rst(rst[1]), .sample_valid(sv[1]), .sample_ready(rdy1),
    .wr_en(wen1), .wr_ptr(wp1), .rd_ptr(rp1), .coef_addr(ca1), .mac_en(me1),
    .mac_clear(mc1), .result_valid(rv1), .overrun(ov1), .overrun_clr(clr[1])
  );

  int nt[2] = '{16, 5};
  int lt[2] = '{2, 0};

  int age[2];
  int base_m[2];
  int wrp_m[2];
  bit ovr_m[2];
  bit post_rst[2];

  int ncmp  = 0;
  int nfail = 0;

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  function automatic bit m_busy(input int i);
    return (age[i] >= 1) && (age[i] < nt[i] + lt[i] + 1);
  endfunction

  function automatic bit m_ready(input int i);
    return !m_busy(i) && !rst[i];
  endfunction

  task automatic drive(input bit v, input bit c, input bit r);
    for (int i = 0; i < 2; i++) begin
      sv[i]  = v;
      clr[i] = c;
      rst[i] = r;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] ordy, owen, owp, ord, oca, ome, omc, orv, oov;
      int a;
      bit rdy, me;
      if (i == 0) begin
        ordy = 32'(rdy0); owen = 32'(wen0); owp = 32'(wp0); ord = 32'(rp0); oca = 32'(ca0);
        ome  = 32'(me0);  omc  = 32'(mc0);  orv = 32'(rv0); oov = 32'(ov0);
      end else begin
        ordy = 32'(rdy1); owen = 32'(wen1); owp = 32'(wp1); ord = 32'(rp1); oca = 32'(ca1);
        ome  = 32'(me1);  omc  = 32'(mc1);  orv = 32'(rv1); oov = 32'(ov1);
      end
      a   = age[i];
      rdy = m_ready(i);
      me  = (a >= 1) && (a <= nt[i]);

      chk("sample_ready", i, ordy, 32'(rdy));
      chk("wr_en",        i, owen, 32'(rdy && sv[i]));
      chk("wr_ptr",       i, owp,  32'(wrp_m[i]));
      chk("mac_en",       i, ome,  32'(me));
      chk("mac_clear",    i, omc,  32'(a == 1));
      chk("result_valid", i, orv,  32'(a == nt[i] + lt[i] + 1));
      chk("overrun",      i, oov,  32'(ovr_m[i]));
      if (me) begin
        chk("coef_addr", i, oca, 32'(a - 1));
        chk("rd_ptr",    i, ord, 32'((base_m[i] + nt[i] - (a - 1)) % nt[i]));
      end else if (post_rst[i]) begin
        chk("coef_addr_rst", i, oca, 32'd0);
        chk("rd_ptr_rst",    i, ord, 32'd0);
      end

      post_rst[i] = rst[i];
      if (rst[i]) begin
        age[i]   = -1;
        wrp_m[i] = 0;
        ovr_m[i] = 1'b0;
      end else begin
        if (rdy && sv[i]) begin
          age[i]    = 1;
          base_m[i] = wrp_m[i];
          wrp_m[i]  = (wrp_m[i] + 1) % nt[i];
        end else if (m_busy(i)) begin
          age[i]++;
        end else begin
          age[i] = -1;
        end
        if (sv[i] && !rdy) ovr_m[i] = 1'b1;
        else if (clr[i])   ovr_m[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      age[i] = -1; base_m[i] = 0; wrp_m[i] = 0; ovr_m[i] = 1'b0; post_rst[i] = 1'b1;
    end
    tick();
    drive(0, 0, 0);
    repeat (2) tick();

    // single sample, then drain fully
    drive(1, 0, 0); tick();
    drive(0, 0, 0); repeat (22) tick();

    // back-to-back: offer exactly when the model says the sequencer is ready
    repeat (20 * 19) begin
      for (int i = 0; i < 2; i++) begin
        sv[i] = m_ready(i); clr[i] = 1'b0; rst[i] = 1'b0;
      end
      tick();
    end
    drive(0, 0, 0); repeat (22) tick();

    // drop during RUN, then clear coincident with a second drop, then plain clear
    drive(1, 0, 0); tick();
    drive(0, 0, 0); repeat (4) tick();
    drive(1, 0, 0); tick();
    drive(0, 0, 0); repeat (5) tick();
    drive(1, 1, 0); tick();
    drive(0, 1, 0); tick();
    drive(0, 0, 0); repeat (22) tick();

    // reset in cycle 10 of a computation
    drive(1, 0, 0); tick();
    drive(0, 0, 0); repeat (9) tick();
    drive(0, 0, 1); tick();
    drive(0, 0, 0); repeat (25) tick();

    // random traffic
    repeat (800) begin
      for (int i = 0; i < 2; i++) begin
        sv[i]  = ($urandom_range(3) == 0);
        clr[i] = ($urandom_range(15) == 0);
        rst[i] = ($urandom_range(63) == 0);
      end
      tick();
    end
    drive(0, 0, 0); repeat (25) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
